// File: rtl/io_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : io_clock_monitor
// Description : Health monitor for an external clock. Counts rising edges of
//               the asynchronous mon_clk over a fixed window of clk cycles.
//               Each window reports the count and flags a stopped clock
//               (lost) or an off-frequency clock (out_of_range).
//               Optional feature macro IO_CLOCK_MONITOR_MINMAX_EN adds
//               shortest/longest mon_clk period tracking (period_min/max).
// Revision    : 1.0 - initial release
// ============================================================================
module io_clock_monitor #(
    parameter int GATE_CYCLES = 1000,
    parameter int COUNT_WIDTH = 16,
    parameter int EXP_MIN     = 0,
    parameter int EXP_MAX     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   mon_clk,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   valid,
    output logic                   lost,
    output logic                   out_of_range
`ifdef IO_CLOCK_MONITOR_MINMAX_EN
    ,
    output logic [COUNT_WIDTH-1:0] period_min,
    output logic [COUNT_WIDTH-1:0] period_max
`endif
);

    localparam int                     c_gate_w    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_gate_w-1:0]    c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] c_cnt_max   = '1;
    localparam logic [32:0]            c_exp_min   = 33'(EXP_MIN);
    localparam logic [32:0]            c_exp_max   = 33'(EXP_MAX);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_publish;
    logic                   w_clear;
    logic                   w_terminal;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [SYNC_STAGES:0]   r_prime;
    logic                   w_edge;

    logic [c_gate_w-1:0]    r_gate;
    logic [COUNT_WIDTH-1:0] r_edge_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_next;
    logic [32:0]            w_cnt_ext;
    logic                   w_below;
    logic                   w_above;

    // Synchronize mon_clk and keep a history flop; r_prime marks when the
    // history flop holds a genuine post-reset sample, so a mon_clk already
    // high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_prime <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], mon_clk};
            r_hist  <= r_sync[SYNC_STAGES-1];
            r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_hist & r_prime[SYNC_STAGES];
    assign w_terminal = (r_gate == c_gate_last);

    // Edge count including this cycle's edge, saturating instead of wrapping.
    assign w_cnt_next = (w_edge && (r_edge_cnt != c_cnt_max)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_cnt_ext  = {{(33-COUNT_WIDTH){1'b0}}, w_cnt_next};
    // count < EXP_MIN written as count+1 <= EXP_MIN so EXP_MIN=0 needs no special case
    assign w_below    = ((w_cnt_ext + 33'd1) <= c_exp_min);
    assign w_above    = (w_cnt_ext > c_exp_max);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: terminal cycle always publishes; a mid-window enable drop
    // abandons the partial window.
    always_comb begin
        w_state_next = r_state;
        w_publish    = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (enable) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_terminal) begin
                    w_publish = 1'b1;
                    w_clear   = 1'b1;
                    if (!enable) begin
                        w_state_next = ST_IDLE;
                    end
                end else if (!enable) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Gate/edge counters and per-window published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate       <= '0;
            r_edge_cnt   <= '0;
            count        <= '0;
            valid        <= 1'b0;
            lost         <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            valid <= w_publish;
            if (w_publish) begin
                count        <= w_cnt_next;
                lost         <= (w_cnt_next == '0);
                out_of_range <= w_below | w_above;
            end
            if (w_clear) begin
                r_gate     <= '0;
                r_edge_cnt <= '0;
            end else begin
                r_gate     <= r_gate + 1'b1;
                r_edge_cnt <= w_cnt_next;
            end
        end
    end

`ifdef IO_CLOCK_MONITOR_MINMAX_EN
    logic [COUNT_WIDTH-1:0] r_period;
    logic [COUNT_WIDTH-1:0] r_pmin;
    logic [COUNT_WIDTH-1:0] r_pmax;
    logic [COUNT_WIDTH-1:0] w_pmin_next;
    logic [COUNT_WIDTH-1:0] w_pmax_next;
    logic                   r_armed;
    logic                   w_meas_edge;

    assign w_meas_edge = w_edge & (r_state == ST_MEASURE);

    // Fold the period ending on this cycle's edge into the trackers.
    always_comb begin
        w_pmin_next = r_pmin;
        w_pmax_next = r_pmax;
        if (w_meas_edge && r_armed) begin
            if (r_period < r_pmin) begin
                w_pmin_next = r_period;
            end
            if (r_period > r_pmax) begin
                w_pmax_next = r_period;
            end
        end
    end

    // Period counter and trackers; every window only measures periods that
    // begin inside it, so a window with fewer than two edges publishes the
    // empty markers (all-ones / zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period   <= '0;
            r_armed    <= 1'b0;
            r_pmin     <= '1;
            r_pmax     <= '0;
            period_min <= '1;
            period_max <= '0;
        end else begin
            if (w_publish) begin
                period_min <= w_pmin_next;
                period_max <= w_pmax_next;
            end
            if (w_clear) begin
                r_period <= '0;
                r_armed  <= 1'b0;
                r_pmin   <= '1;
                r_pmax   <= '0;
            end else begin
                r_pmin <= w_pmin_next;
                r_pmax <= w_pmax_next;
                if (w_meas_edge) begin
                    r_period <= COUNT_WIDTH'(1);
                    r_armed  <= 1'b1;
                end else if (r_period != c_cnt_max) begin
                    r_period <= r_period + 1'b1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
